// File: rtl/rpn_pkg.sv
// rpn_pkg: key codes, FSM states and operator encodings shared by the
// reverse-Polish calculator core and its helpers.
package rpn_pkg;

  typedef enum logic [4:0] {
    K_D0    = 5'd0,
    K_D1    = 5'd1,
    K_D2    = 5'd2,
    K_D3    = 5'd3,
    K_D4    = 5'd4,
    K_D5    = 5'd5,
    K_D6    = 5'd6,
    K_D7    = 5'd7,
    K_D8    = 5'd8,
    K_D9    = 5'd9,
    K_ENTER = 5'd10,
    K_ADD   = 5'd11,
    K_SUB   = 5'd12,
    K_MUL   = 5'd13,
    K_DROP  = 5'd14,
    K_SWAP  = 5'd15,
    K_CLEAR = 5'd16
  } key_t;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_PUSH     = 2'd1,
    S_EXEC     = 2'd2,
    S_MUL_WAIT = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2
  } op_t;

  function automatic logic key_is_digit(input key_t k);
    return (k <= K_D9);
  endfunction

  function automatic op_t key_to_op(input key_t k);
    op_t op;
    case (k)
      K_SUB:   op = OP_SUB;
      K_MUL:   op = OP_MUL;
      default: op = OP_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/rpn_mul_seq.sv
// rpn_mul_seq: iterative shift-add unsigned multiplier, one multiplier bit
// per cycle; product is truncated to Width bits.
module rpn_mul_seq #(
  parameter int Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  output logic             done_o,
  output logic [Width-1:0] product_o
);

  localparam int CW = $clog2(Width + 1);

  logic [Width-1:0] a_r;
  logic [Width-1:0] b_r;
  logic [Width-1:0] acc_r;
  logic [CW-1:0]    cnt_r;
  logic             run_r;
  logic             done_r;

  // Shift-add datapath; the start edge already consumes bit 0 so done lands
  // exactly Width edges after start.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a_r    <= '0;
      b_r    <= '0;
      acc_r  <= '0;
      cnt_r  <= '0;
      run_r  <= 1'b0;
      done_r <= 1'b0;
    end else if (start_i) begin
      acc_r  <= b_i[0] ? a_i : '0;
      a_r    <= {a_i[Width-2:0], 1'b0};
      b_r    <= {1'b0, b_i[Width-1:1]};
      cnt_r  <= CW'(1);
      run_r  <= 1'b1;
      done_r <= 1'b0;
    end else if (run_r) begin
      if (b_r[0]) begin
        acc_r <= acc_r + a_r;
      end
      a_r   <= {a_r[Width-2:0], 1'b0};
      b_r   <= {1'b0, b_r[Width-1:1]};
      cnt_r <= cnt_r + CW'(1);
      if (cnt_r == CW'(Width - 1)) begin
        run_r  <= 1'b0;
        done_r <= 1'b1;
      end else begin
        done_r <= 1'b0;
      end
    end else begin
      done_r <= 1'b0;
    end
  end

  assign done_o    = done_r;
  assign product_o = acc_r;

endmodule

// File: rtl/rpn_calc_core.sv
// rpn_calc_core: reverse-Polish calculator core with decimal digit entry, a
// Depth-entry operand stack, combinational ADD/SUB and sequential MUL.
module rpn_calc_core
  import rpn_pkg::*;
#(
  parameter int Width     = 32,
  parameter int Depth     = 8,
  parameter int NumDigits = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       key_valid_i,
  input  key_t                       key_i,
  output logic                       key_ready_o,
  output logic [Width-1:0]           display_o,
  output logic [$clog2(Depth+1)-1:0] depth_o,
  output logic                       entry_active_o,
  output logic                       error_o,
  output logic                       busy_o
);

  localparam int DW = $clog2(Depth + 1);
  localparam int AW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int CW = $clog2(NumDigits + 1);

  state_t           state_r, state_n;
  op_t              op_r, op_n;
  logic [Width-1:0] stack_r [Depth];
  logic [Width-1:0] stack_n [Depth];
  logic [DW-1:0]    depth_r, depth_n;
  logic [Width-1:0] entry_r, entry_n;
  logic [CW-1:0]    count_r, count_n;
  logic             active_r, active_n;
  logic             error_r, error_n;
  logic             ready_r, busy_r;
  logic [Width-1:0] display_r, display_n;

  logic [AW-1:0]    top_idx_s, sec_idx_s, push_idx_s, disp_idx_s;
  logic [Width-1:0] top_s, sec_s;
  logic             full_s, empty_s, has_two_s, accept_s;
  logic             mul_start_s, mul_done_s;
  logic [Width-1:0] mul_a_s, mul_b_s, mul_product_s;

  function automatic logic [Width-1:0] alu(input op_t op, input logic [Width-1:0] a,
                                           input logic [Width-1:0] b);
    logic [Width-1:0] r;
    case (op)
      OP_SUB:  r = a - b;
      default: r = a + b;
    endcase
    return r;
  endfunction

  rpn_mul_seq #(.Width(Width)) u_mul (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .start_i   (mul_start_s),
    .a_i       (mul_a_s),
    .b_i       (mul_b_s),
    .done_o    (mul_done_s),
    .product_o (mul_product_s)
  );

  assign top_idx_s  = AW'(depth_r - DW'(1));
  assign sec_idx_s  = AW'(depth_r - DW'(2));
  assign push_idx_s = AW'(depth_r);
  assign top_s      = stack_r[top_idx_s];
  assign sec_s      = stack_r[sec_idx_s];
  assign full_s     = (depth_r == DW'(Depth));
  assign empty_s    = (depth_r == DW'(0));
  assign has_two_s  = (depth_r >= DW'(2));
  assign accept_s   = key_valid_i && ready_r;

  // Next-state and datapath decode; a pending entry is pushed and combined
  // with the old top in the single PUSH cycle.
  always_comb begin
    state_n     = state_r;
    op_n        = op_r;
    stack_n     = stack_r;
    depth_n     = depth_r;
    entry_n     = entry_r;
    count_n     = count_r;
    active_n    = active_r;
    error_n     = error_r;
    mul_start_s = 1'b0;
    mul_a_s     = '0;
    mul_b_s     = '0;
    case (state_r)
      S_IDLE: begin
        if (!accept_s) begin
          state_n = S_IDLE;
        end else if (key_is_digit(key_i)) begin
          if (count_r < CW'(NumDigits)) begin
            entry_n  = entry_r * Width'(32'd10) + Width'(key_i);
            count_n  = count_r + CW'(1);
            active_n = 1'b1;
          end else begin
            entry_n = entry_r;
          end
        end else begin
          case (key_i)
            K_ENTER: begin
              entry_n  = '0;
              count_n  = '0;
              active_n = 1'b0;
              if (full_s || (!active_r && empty_s)) begin
                error_n = 1'b1;
              end else begin
                stack_n[push_idx_s] = active_r ? entry_r : top_s;
                depth_n             = depth_r + DW'(1);
              end
            end
            K_DROP: begin
              if (empty_s) begin
                error_n = 1'b1;
              end else begin
                depth_n = depth_r - DW'(1);
              end
            end
            K_SWAP: begin
              if (!has_two_s) begin
                error_n = 1'b1;
              end else begin
                stack_n[top_idx_s] = sec_s;
                stack_n[sec_idx_s] = top_s;
              end
            end
            K_CLEAR: begin
              depth_n  = '0;
              entry_n  = '0;
              count_n  = '0;
              active_n = 1'b0;
              error_n  = 1'b0;
            end
            K_ADD, K_SUB, K_MUL: begin
              op_n    = key_to_op(key_i);
              state_n = active_r ? S_PUSH : S_EXEC;
            end
            default: state_n = S_IDLE;
          endcase
        end
      end
      S_PUSH: begin
        entry_n  = '0;
        count_n  = '0;
        active_n = 1'b0;
        if (full_s) begin
          error_n = 1'b1;
          state_n = S_IDLE;
        end else if (empty_s) begin
          stack_n[push_idx_s] = entry_r;
          depth_n             = depth_r + DW'(1);
          error_n             = 1'b1;
          state_n             = S_IDLE;
        end else if (op_r == OP_MUL) begin
          stack_n[push_idx_s] = entry_r;
          depth_n             = depth_r + DW'(1);
          mul_start_s         = 1'b1;
          mul_a_s             = top_s;
          mul_b_s             = entry_r;
          state_n             = S_MUL_WAIT;
        end else begin
          stack_n[top_idx_s] = alu(op_r, top_s, entry_r);
          state_n            = S_IDLE;
        end
      end
      S_EXEC: begin
        if (!has_two_s) begin
          error_n = 1'b1;
          state_n = S_IDLE;
        end else if (op_r == OP_MUL) begin
          mul_start_s = 1'b1;
          mul_a_s     = sec_s;
          mul_b_s     = top_s;
          state_n     = S_MUL_WAIT;
        end else begin
          stack_n[sec_idx_s] = alu(op_r, sec_s, top_s);
          depth_n            = depth_r - DW'(1);
          state_n            = S_IDLE;
        end
      end
      S_MUL_WAIT: begin
        if (mul_done_s) begin
          stack_n[sec_idx_s] = mul_product_s;
          depth_n            = depth_r - DW'(1);
          state_n            = S_IDLE;
        end else begin
          state_n = S_MUL_WAIT;
        end
      end
      default: state_n = S_IDLE;
    endcase

    disp_idx_s = AW'(depth_n - DW'(1));
    if (active_n) begin
      display_n = entry_n;
    end else if (depth_n != DW'(0)) begin
      display_n = stack_n[disp_idx_s];
    end else begin
      display_n = '0;
    end
  end

  // State, stack and registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r   <= S_IDLE;
      op_r      <= OP_ADD;
      for (int i = 0; i < Depth; i++) begin
        stack_r[i] <= '0;
      end
      depth_r   <= '0;
      entry_r   <= '0;
      count_r   <= '0;
      active_r  <= 1'b0;
      error_r   <= 1'b0;
      ready_r   <= 1'b0;
      busy_r    <= 1'b0;
      display_r <= '0;
    end else begin
      state_r   <= state_n;
      op_r      <= op_n;
      stack_r   <= stack_n;
      depth_r   <= depth_n;
      entry_r   <= entry_n;
      count_r   <= count_n;
      active_r  <= active_n;
      error_r   <= error_n;
      ready_r   <= (state_n == S_IDLE);
      busy_r    <= (state_n == S_MUL_WAIT);
      display_r <= display_n;
    end
  end

  assign key_ready_o    = ready_r;
  assign display_o      = display_r;
  assign depth_o        = depth_r;
  assign entry_active_o = active_r;
  assign error_o        = error_r;
  assign busy_o         = busy_r;

endmodule

// File: tb/tb_rpn_calc_core.sv
// Directed testbench for rpn_calc_core with hand-computed expected values.
module tb_rpn_calc_core;
  import rpn_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        key_valid;
  key_t        key;
  logic        key_ready;
  logic [31:0] display;
  logic [3:0]  depth;
  logic        entry_active;
  logic        error;
  logic        busy;

  int checks;
  int failures;

  rpn_calc_core #(.Width(32), .Depth(8), .NumDigits(8)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .key_valid_i    (key_valid),
    .key_i          (key),
    .key_ready_o    (key_ready),
    .display_o      (display),
    .depth_o        (depth),
    .entry_active_o (entry_active),
    .error_o        (error),
    .busy_o         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic press(input key_t k);
    int n;
    n = 0;
    @(negedge clk);
    while (!key_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (key_ready !== 1'b1) begin
      failures++;
      $display("FAIL press_ready_timeout key=%0d ready=%b expected 1", k, key_ready);
    end
    key = k;
    key_valid = 1'b1;
    @(posedge clk);
    #1;
    key_valid = 1'b0;
  endtask

  task automatic press_num(input int unsigned v);
    int unsigned d[10];
    int n;
    n = 0;
    do begin
      d[n] = v % 10;
      v = v / 10;
      n++;
    end while (v > 0 && n < 10);
    for (int i = n - 1; i >= 0; i--) press(key_t'(d[i][4:0]));
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (!key_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (key_ready !== 1'b1) begin
      failures++;
      $display("FAIL idle_timeout ready=%b expected 1", key_ready);
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    key_valid = 1'b0;
    key = K_D0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    key_valid = 1'b0;
    key = K_D0;
    #1;
    checks++;
    if ({key_ready, display, depth, entry_active, error, busy} !== 40'd0) begin
      failures++;
      $display("FAIL reset_outputs got rdy=%b disp=%0d dep=%0d act=%b err=%b busy=%b expected all 0",
               key_ready, display, depth, entry_active, error, busy);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (key_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_ready_before_edge got=%b expected 0", key_ready);
    end
    @(posedge clk);
    #1;
    checks++;
    if (key_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready_after_edge got=%b expected 1", key_ready);
    end
  endtask

  task automatic test_add();
    int low;
    press_num(12);
    press(K_ENTER);
    press_num(30);
    press(K_ADD);
    low = 0;
    while (!key_ready && low < 50) begin
      low++;
      @(posedge clk);
      #1;
    end
    checks++;
    if (low !== 1) begin
      failures++;
      $display("FAIL add_ready_low_cycles got=%0d expected 1", low);
    end
    checks++;
    if (display !== 32'd42 || depth !== 4'd1 || error !== 1'b0) begin
      failures++;
      $display("FAIL add_result got disp=%0d dep=%0d err=%b expected 42/1/0", display, depth, error);
    end
    press(K_CLEAR);
  endtask

  task automatic test_sub();
    press_num(5);
    press(K_ENTER);
    press_num(7);
    press(K_SUB);
    wait_idle();
    checks++;
    if (display !== 32'hFFFF_FFFE || depth !== 4'd1) begin
      failures++;
      $display("FAIL sub_wrap got disp=%h dep=%0d expected fffffffe/1", display, depth);
    end
    press(K_CLEAR);
  endtask

  task automatic test_stack_ops();
    press_num(3);
    press(K_ENTER);
    press_num(4);
    press(K_ENTER);
    press(K_ADD);
    wait_idle();
    checks++;
    if (display !== 32'd7 || depth !== 4'd1) begin
      failures++;
      $display("FAIL add_no_entry got disp=%0d dep=%0d expected 7/1", display, depth);
    end
    press_num(6);
    press(K_ENTER);
    press(K_SWAP);
    checks++;
    if (display !== 32'd7 || depth !== 4'd2 || error !== 1'b0) begin
      failures++;
      $display("FAIL swap got disp=%0d dep=%0d err=%b expected 7/2/0", display, depth, error);
    end
    press(K_DROP);
    checks++;
    if (display !== 32'd6 || depth !== 4'd1) begin
      failures++;
      $display("FAIL drop got disp=%0d dep=%0d expected 6/1", display, depth);
    end
    press(K_ENTER);
    checks++;
    if (display !== 32'd6 || depth !== 4'd2 || error !== 1'b0) begin
      failures++;
      $display("FAIL dup got disp=%0d dep=%0d err=%b expected 6/2/0", display, depth, error);
    end
    press(key_t'(5'd20));
    checks++;
    if (display !== 32'd6 || depth !== 4'd2 || error !== 1'b0 || entry_active !== 1'b0) begin
      failures++;
      $display("FAIL undefined_key got disp=%0d dep=%0d err=%b act=%b expected 6/2/0/0",
               display, depth, error, entry_active);
    end
    press(K_CLEAR);
  endtask

  task automatic test_mul();
    int busy_cnt;
    int n;
    press_num(1234);
    press(K_ENTER);
    press_num(5678);
    press(K_MUL);
    key = K_D9;
    key_valid = 1'b1;
    busy_cnt = 0;
    n = 0;
    while (!key_ready && n < 200) begin
      if (busy) busy_cnt++;
      @(posedge clk);
      #1;
      n++;
    end
    key_valid = 1'b0;
    checks++;
    if (busy_cnt !== 32) begin
      failures++;
      $display("FAIL mul_busy_cycles got=%0d expected 32", busy_cnt);
    end
    checks++;
    if (display !== 32'd7006652 || depth !== 4'd1 || entry_active !== 1'b0) begin
      failures++;
      $display("FAIL mul_result got disp=%0d dep=%0d act=%b expected 7006652/1/0",
               display, depth, entry_active);
    end
    press(K_CLEAR);
  endtask

  task automatic test_overflow();
    for (int v = 1; v <= 9; v++) begin
      press_num(v);
      press(K_ENTER);
    end
    checks++;
    if (error !== 1'b1 || depth !== 4'd8 || display !== 32'd8) begin
      failures++;
      $display("FAIL overflow got err=%b dep=%0d disp=%0d expected 1/8/8", error, depth, display);
    end
    press(K_CLEAR);
    checks++;
    if (error !== 1'b0 || depth !== 4'd0 || display !== 32'd0) begin
      failures++;
      $display("FAIL clear got err=%b dep=%0d disp=%0d expected 0/0/0", error, depth, display);
    end
  endtask

  task automatic test_empty();
    press(K_ADD);
    wait_idle();
    checks++;
    if (error !== 1'b1 || depth !== 4'd0) begin
      failures++;
      $display("FAIL empty_add got err=%b dep=%0d expected 1/0", error, depth);
    end
    press(K_DROP);
    press(K_SWAP);
    checks++;
    if (error !== 1'b1 || depth !== 4'd0 || display !== 32'd0) begin
      failures++;
      $display("FAIL empty_drop_swap got err=%b dep=%0d disp=%0d expected 1/0/0", error, depth, display);
    end
    press(K_CLEAR);
  endtask

  task automatic test_digit_limit();
    for (int d = 1; d <= 9; d++) press(key_t'(d[4:0]));
    checks++;
    if (display !== 32'd12345678 || entry_active !== 1'b1 || error !== 1'b0) begin
      failures++;
      $display("FAIL digit_limit got disp=%0d act=%b err=%b expected 12345678/1/0",
               display, entry_active, error);
    end
    press(K_CLEAR);
  endtask

  task automatic test_mul_reset();
    press_num(3);
    press(K_ENTER);
    press_num(4);
    press(K_MUL);
    repeat (5) @(posedge clk);
    #3;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL mul_reset_busy got=%b expected 1", busy);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({key_ready, display, depth, entry_active, error, busy} !== 40'd0) begin
      failures++;
      $display("FAIL mul_reset_async got rdy=%b disp=%0d dep=%0d act=%b err=%b busy=%b expected all 0",
               key_ready, display, depth, entry_active, error, busy);
    end
    apply_reset();
  endtask

  task automatic test_back_to_back();
    press_num(3);
    press(K_ENTER);
    press_num(4);
    press(K_ENTER);
    press(K_MUL);
    press_num(10);
    press(K_ADD);
    wait_idle();
    checks++;
    if (display !== 32'd22 || depth !== 4'd1 || error !== 1'b0) begin
      failures++;
      $display("FAIL back_to_back got disp=%0d dep=%0d err=%b expected 22/1/0", display, depth, error);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_add();
    test_sub();
    test_stack_ops();
    test_mul();
    test_overflow();
    test_empty();
    test_digit_limit();
    test_mul_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
